// File: rtl/comp_pkg.sv
// rtl/comp_pkg.sv - shared types and constants for the serial magnitude comparator
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [1:0] DEC_EQ = 2'd0;
  localparam logic [1:0] DEC_LT = 2'd1;
  localparam logic [1:0] DEC_GT = 2'd2;

  localparam int N_DEFAULT = 8;

endpackage

// File: rtl/comp1.sv
// rtl/comp1.sv - 1-bit magnitude comparator slice
module comp1 (
  input  logic a,
  input  logic b,
  output logic lt,
  output logic gt,
  output logic eq
);

  assign lt = ~a & b;
  assign gt = a & ~b;
  assign eq = ~(a ^ b);

endmodule

// File: rtl/serial_mag_comp.sv
// rtl/serial_mag_comp.sv - bit-serial N-bit magnitude comparator, MSB first
module serial_mag_comp
  import comp_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic lt,
  output logic gt,
  output logic eq
);

  localparam int CW = $clog2(N);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    dec, dec_n, dec_bit;
  logic          load;
  logic          c_lt, c_gt, c_eq;

  comp1 u_comp1 (
    .a  (a_bit),
    .b  (b_bit),
    .lt (c_lt),
    .gt (c_gt),
    .eq (c_eq)
  );

  assign dec_bit = c_eq ? DEC_EQ : (c_lt ? DEC_LT : DEC_GT);

  // Results are loaded on the edge entering FIN so they appear alongside done.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dec_n   = dec;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          dec_n   = dec_bit;
          cnt_n   = CW'(N - 2);
          state_n = RUN;
        end
      end
      RUN: begin
        if (dec == DEC_EQ) dec_n = dec_bit;
        if (cnt == '0) begin
          state_n = FIN;
          load    = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dec   <= DEC_EQ;
      lt    <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dec   <= dec_n;
      if (load) begin
        lt <= (dec_n == DEC_LT);
        gt <= (dec_n == DEC_GT);
        eq <= (dec_n == DEC_EQ);
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == FIN);

endmodule

// File: tb/tb_serial_mag_comp.sv
// tb/tb_serial_mag_comp.sv - self-checking bench for serial_mag_comp (N=8 and N=2)
module tb_serial_mag_comp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start = 1'b0, a_bit = 1'b0, b_bit = 1'b0, sel8 = 1'b1;
  logic start8, start2;
  logic busy8, done8, lt8, gt8, eq8;
  logic busy2, done2, lt2, gt2, eq2;
  logic busy_o, done_o, lt_o, gt_o, eq_o;

  assign start8 = start & sel8;
  assign start2 = start & ~sel8;

  serial_mag_comp #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_bit(a_bit), .b_bit(b_bit),
    .busy(busy8), .done(done8), .lt(lt8), .gt(gt8), .eq(eq8)
  );

  serial_mag_comp #(.N(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a_bit(a_bit), .b_bit(b_bit),
    .busy(busy2), .done(done2), .lt(lt2), .gt(gt2), .eq(eq2)
  );

  assign busy_o = sel8 ? busy8 : busy2;
  assign done_o = sel8 ? done8 : done2;
  assign lt_o   = sel8 ? lt8   : lt2;
  assign gt_o   = sel8 ? gt8   : gt2;
  assign eq_o   = sel8 ? eq8   : eq2;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one full compare starting in the current cycle (T0) and checks
  // busy/done every cycle plus the result at T(n); returns positioned at T(n+1).
  task automatic run_cmp(input int n, input logic [31:0] a, input logic [31:0] b,
                         input int stray_k, input logic e_lt, input logic e_gt,
                         input logic e_eq, input string tag);
    sel8 = (n == 8);
    for (int k = 0; k <= n; k++) begin
      start = (k == 0) || (k == stray_k);
      if (k < n) begin
        a_bit = a[n-1-k];
        b_bit = b[n-1-k];
      end else begin
        a_bit = 1'($urandom);
        b_bit = 1'($urandom);
      end
      chk($sformatf("%s T%0d busy", tag, k), int'(busy_o), int'(k >= 1 && k < n));
      chk($sformatf("%s T%0d done", tag, k), int'(done_o), int'(k == n));
      if (k == n) begin
        chk($sformatf("%s lt", tag), int'(lt_o), int'(e_lt));
        chk($sformatf("%s gt", tag), int'(gt_o), int'(e_gt));
        chk($sformatf("%s eq", tag), int'(eq_o), int'(e_eq));
      end
      step();
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       lt;
    logic       gt;
    logic       eq;
  } vec_t;

  vec_t tab[7];

  initial begin
    logic [31:0] ra, rb;

    tab[0] = '{8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1};
    tab[1] = '{8'h80, 8'h7F, 1'b0, 1'b1, 1'b0};
    tab[2] = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0};
    tab[3] = '{8'hFF, 8'h00, 1'b0, 1'b1, 1'b0};
    tab[4] = '{8'h7E, 8'h7F, 1'b1, 1'b0, 1'b0};
    tab[5] = '{8'hC3, 8'hC2, 1'b0, 1'b1, 1'b0};
    tab[6] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1};

    // Reset state, then confirm outputs stay 0 before any done.
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy8", int'(busy8), 0);
    chk("rst done8", int'(done8), 0);
    chk("rst res8", int'({lt8, gt8, eq8}), 0);
    chk("rst busy2", int'(busy2), 0);
    chk("rst res2", int'({lt2, gt2, eq2}), 0);
    rst = 1'b0;
    step();
    step();
    chk("pre-done res8", int'({lt8, gt8, eq8}), 0);

    for (int i = 0; i < 7; i++)
      run_cmp(8, 32'(tab[i].a), 32'(tab[i].b), -1, tab[i].lt, tab[i].gt, tab[i].eq,
              $sformatf("tab%0d", i));

    // Only the LSB differs; result must hold through idle cycles.
    run_cmp(8, 32'h12, 32'h13, -1, 1'b1, 1'b0, 1'b0, "lsb");
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("hold%0d lt", i), int'(lt8), 1);
      chk($sformatf("hold%0d gt/eq", i), int'({gt8, eq8}), 0);
      chk($sformatf("hold%0d done", i), int'(done8), 0);
      step();
    end

    // Back-to-back with a stray start at T4; second start lands at T9.
    run_cmp(8, 32'h01, 32'h02, 4, 1'b1, 1'b0, 1'b0, "b2b_a");
    run_cmp(8, 32'hFF, 32'hFF, -1, 1'b0, 1'b0, 1'b1, "b2b_b");

    // Asynchronous reset in the middle of T3, released at T5.
    sel8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start = (k == 0);
      a_bit = 1'b1;
      b_bit = 1'b0;
      step();
    end
    start = 1'b0;
    chk("pre-abort busy", int'(busy8), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("abort busy", int'(busy8), 0);
    chk("abort done", int'(done8), 0);
    chk("abort res", int'({lt8, gt8, eq8}), 0);
    step();
    chk("abort T4 done", int'(done8), 0);
    step();
    rst = 1'b0;
    chk("abort T5 done", int'(done8), 0);
    step();
    run_cmp(8, 32'h40, 32'h41, -1, 1'b1, 1'b0, 1'b0, "post_rst");

    // N=2 boundary, exhaustive against the arithmetic model.
    run_cmp(2, 32'h1, 32'h2, -1, 1'b1, 1'b0, 1'b0, "n2_01_10");
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        run_cmp(2, 32'(x), 32'(y), -1, x < y, x > y, x == y, $sformatf("n2_%0d_%0d", x, y));

    // Randomized N=8 compares against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = 32'($urandom_range(0, 255));
      rb = (i % 4 == 0) ? ra : 32'($urandom_range(0, 255));
      run_cmp(8, ra, rb, (i % 5 == 0) ? int'($urandom_range(1, 8)) : -1,
              ra < rb, ra > rb, ra == rb, $sformatf("rnd%0d_%0h_%0h", i, ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_mag_comp.md
# serial_mag_comp

Bit-serial N-bit magnitude comparator built directly downstream of the existing 1-bit comparator `comp1`. Each cycle it feeds one bit pair, MSB first, into a `comp1` instance and consumes that instance's `lt`/`gt`/`eq` outputs. A small FSM latches the first unequal bit position as the word result. It produces registered word-level `lt`/`gt`/`eq` with a one-cycle `done` pulse, letting the team compare wide operands with a single 1-bit slice.

## Interface

Parameters:
- `N`, default 8: operand width in bits; legal range 2..32.

Ports (clock and reset first):
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begin a compare; the same cycle carries bit N-1.
- `a_bit`, in, 1: serial operand A bit, MSB first.
- `b_bit`, in, 1: serial operand B bit, MSB first.
- `busy`, out, 1: high while bits N-2..0 are being accepted.
- `done`, out, 1: one-cycle pulse; result valid from this cycle.
- `lt`, out, 1: A < B, registered, held until the next `done`.
- `gt`, out, 1: A > B, registered, held.
- `eq`, out, 1: A == B, registered, held.

## Operation

- States: `IDLE`, `RUN`, `FIN`.
- `IDLE`:
  - `start`=1: evaluate `comp1`(a_bit, b_bit). The decision register takes LT, GT or EQ (still undecided). `cnt` = N-2. Go to `RUN`.
  - `start`=0: stay.
- `RUN`: each cycle sample one bit pair, bit index = `cnt`.
  - Decision already LT/GT: keep it; the remaining bits are consumed but ignored.
  - Decision still EQ: take the `comp1` result for this bit.
  - `cnt`==0: go to `FIN`. Otherwise decrement `cnt`.
- `FIN`, one cycle:
  - Copy the decision into the `lt`/`gt`/`eq` output registers.
  - Pulse `done`. Return to `IDLE`.
- `start` in `RUN` or `FIN` is ignored; no restart or abort.
- Exactly one of `lt`/`gt`/`eq` is high after the first `done`. All three are 0 before it.
- `cnt` width is $clog2(N). It never wraps: the transition to `FIN` happens at 0.

## Timing

- Reset values: state=`IDLE`, `cnt`=0, decision=EQ, `busy`=0, `done`=0, `lt`=`gt`=`eq`=0.
- `rst` is asynchronous. Asserted mid-compare, it aborts immediately to the reset values; no `done` follows.
- Cycle numbering: start cycle = T0 (bit N-1); bit i is sampled at T(N-1-i).
- `busy`=1 during T1..T(N-1); the 0→1 transition is registered on the T0 edge.
- `done`=1 in T(N) only. `lt`/`gt`/`eq` update at the T(N) edge and are visible the same cycle as `done`.
- Latency from `start` to `done`: N cycles.
- Minimum start-to-start spacing: N+1 cycles. `start` in T(N+1) is accepted.
- `a_bit`/`b_bit` are don't-care outside T0..T(N-1).

## Structure

- Shared package `comp_pkg`:
  - state enum `{IDLE, RUN, FIN}`;
  - 2-bit decision encoding `DEC_EQ`, `DEC_LT`, `DEC_GT`;
  - `N_DEFAULT` = 8.
- One sub-module: the existing `comp1`, instantiated once, combinational on `a_bit`/`b_bit`. No other hierarchy.

## Test plan

- N=8, A=0xA5, B=0xA5 serially from T0. `done` at T8 with eq=1, lt=0, gt=0. `busy` high T1..T7.
- N=8, A=0x80, B=0x7F. MSB decides at T0; trailing bits are all A<B but ignored. `done` at T8 with gt=1.
- N=8, A=0x12, B=0x13. Only the LSB differs. `done` at T8 with lt=1; results hold through 20 idle cycles.
- Back-to-back: compare 0x01 vs 0x02, `start` again at T9 with 0xFF vs 0xFF. Two `done` pulses, at T8 (lt=1) and T17 (eq=1). A `start` pulsed at T4 has no effect.
- `rst` asserted mid-cycle at T3 of a compare, released at T5. Outputs drop to 0 asynchronously and no `done` occurs. A new `start` at T6 completes normally at T14.
- N=2 boundary: A=2'b01, B=2'b10. `done` at T2 with lt=1.
